// File: rtl/mem_pkg.sv
// Shared types and default geometry for the burst memory master.
package mem_pkg;

    localparam int unsigned DefM = 3;
    localparam int unsigned DefN = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWr,
        StRdAddr,
        StRdCap,
        StRdRsp,
        StDone
    } state_e;

endpackage

// File: rtl/mem_burst_master_if.sv
// Host command/data streams plus the single-port memory bus of the burst master.
interface mem_burst_master_if
    import mem_pkg::*;
#(
    parameter int unsigned M = DefM,
    parameter int unsigned N = DefN
) ();

    logic         req_valid;
    logic         req_ready;
    logic         req_write;
    logic [M-1:0] req_addr;
    logic [M:0]   req_len;

    logic         wdata_valid;
    logic         wdata_ready;
    logic [N-1:0] wdata;

    logic         rsp_valid;
    logic         rsp_ready;
    logic [N-1:0] rsp_data;
    logic         rsp_last;

    logic         busy;
    logic         done;

    logic [M-1:0] mem_addr;
    logic         mem_wr_enb;
    logic [N-1:0] mem_wr_data;
    logic [N-1:0] mem_rd_data;

    modport master (
        input  req_valid, req_write, req_addr, req_len,
        input  wdata_valid, wdata,
        input  rsp_ready,
        input  mem_rd_data,
        output req_ready, wdata_ready,
        output rsp_valid, rsp_data, rsp_last,
        output busy, done,
        output mem_addr, mem_wr_enb, mem_wr_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_len,
        output wdata_valid, wdata,
        output rsp_ready,
        output mem_rd_data,
        input  req_ready, wdata_ready,
        input  rsp_valid, rsp_data, rsp_last,
        input  busy, done,
        input  mem_addr, mem_wr_enb, mem_wr_data
    );

endinterface

// File: rtl/mem_burst_master.sv
// Burst read/write initiator for a single-port synchronous memory with a
// 1-cycle registered read; addresses wrap modulo the memory size.
module mem_burst_master
    import mem_pkg::*;
#(
    parameter int unsigned M = DefM,
    parameter int unsigned N = DefN
) (
    input logic                clk,
    input logic                rst_n,
    mem_burst_master_if.master bus
);

    localparam logic [M-1:0] AddrOne = M'(1);
    localparam logic [M:0]   CntOne  = (M + 1)'(1);

    state_e       state_q, state_d;
    logic [M-1:0] cur_addr_q, cur_addr_d;
    logic [M:0]   count_q, count_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_last_q, rsp_last_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            count_q     <= '0;
            rsp_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            count_q     <= count_d;
            rsp_data_q  <= rsp_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_last_q  <= rsp_last_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        count_d         = count_q;
        rsp_data_d      = rsp_data_q;
        rsp_valid_d     = rsp_valid_q;
        rsp_last_d      = rsp_last_q;
        bus.req_ready   = 1'b0;
        bus.wdata_ready = 1'b0;
        bus.mem_wr_enb  = 1'b0;

        unique case (state_q)
            StIdle: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    cur_addr_d = bus.req_addr;
                    count_d    = bus.req_len;
                    if (bus.req_len == '0) begin
                        state_d = StDone;
                    end else if (bus.req_write) begin
                        state_d = StWr;
                    end else begin
                        state_d = StRdAddr;
                    end
                end
            end
            StWr: begin
                // Write strobe follows wdata_valid directly so a stalled beat never writes.
                bus.wdata_ready = 1'b1;
                bus.mem_wr_enb  = bus.wdata_valid;
                if (bus.wdata_valid) begin
                    cur_addr_d = cur_addr_q + AddrOne;
                    count_d    = count_q - CntOne;
                    if (count_q == CntOne) begin
                        state_d = StDone;
                    end
                end
            end
            StRdAddr: begin
                state_d = StRdCap;
            end
            StRdCap: begin
                rsp_data_d  = bus.mem_rd_data;
                rsp_valid_d = 1'b1;
                rsp_last_d  = (count_q == CntOne);
                state_d     = StRdRsp;
            end
            StRdRsp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_last_d  = 1'b0;
                    count_d     = count_q - CntOne;
                    if (rsp_last_q) begin
                        state_d = StDone;
                    end else begin
                        cur_addr_d = cur_addr_q + AddrOne;
                        state_d    = StRdAddr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.mem_addr    = cur_addr_q;
    assign bus.mem_wr_data = bus.wdata;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_last    = rsp_last_q;
    assign bus.busy        = (state_q != StIdle);
    assign bus.done        = (state_q == StDone);

endmodule

// File: doc/mem_burst_master.md
Name: mem_burst_master

Overview:
- Initiator that drives a single-port synchronous memory: M-bit address, N-bit data, 1-cycle registered read, write on clock edge when the write enable is high.
- Accepts burst read/write requests on a valid/ready command interface.
- Streams write data in and read data out on valid/ready interfaces.
- Sequences memory addresses with wrap-around.
- Sits between a host/test agent and the memory array.

Parameters:
- M, 3, address width; the memory has 2**M words.
- N, 4, data width.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  command valid
- req_ready  output  1  command accepted when valid&ready
- req_write  input  1  1 = write burst, 0 = read burst
- req_addr  input  M  start address
- req_len  input  M+1  beat count; 0 is legal
- wdata_valid  input  1  write beat valid
- wdata_ready  output  1  write beat accepted when valid&ready
- wdata  input  N  write beat data
- rsp_valid  output  1  read beat valid
- rsp_ready  input  1  read beat consumed when valid&ready
- rsp_data  output  N  read beat data
- rsp_last  output  1  marks final read beat, qualified by rsp_valid
- busy  output  1  state != IDLE
- done  output  1  1-cycle pulse when a burst completes
- mem_addr  output  M  to memory address
- mem_wr_enb  output  1  to memory write enable
- mem_wr_data  output  N  to memory write data
- mem_rd_data  input  N  from memory read data

Behaviour:
- Reset (async assert, sync release): state=IDLE, cur_addr=0, count=0, rsp_data=0, rsp_valid=0, rsp_last=0, done=0. Resulting outputs: mem_wr_enb=0, mem_addr=0, req_ready=1.
- Reset mid-burst aborts the burst immediately. No partial-beat write occurs after rst_n falls. Memory contents are untouched.
- States:
  - IDLE: req_ready=1. On handshake, latch cur_addr=req_addr and count=req_len. Then:
    - len=0 -> DONE.
    - write -> WR.
    - read -> RD_ADDR.
  - WR: wdata_ready=1. mem_wr_enb = wdata_valid (combinational). mem_wr_data = wdata, mem_addr = cur_addr.
    - On accept: cur_addr = cur_addr+1 mod 2**M, count--.
    - If count was 1 -> DONE.
    - No accept -> hold; no write.
  - RD_ADDR: mem_addr=cur_addr, mem_wr_enb=0; -> RD_CAP.
  - RD_CAP: mem_rd_data is now valid for cur_addr. Register rsp_data=mem_rd_data, rsp_valid=1, rsp_last=(count==1); -> RD_RSP.
  - RD_RSP: hold rsp_* stable and mem_addr stable until rsp_ready.
    - On handshake: rsp_valid=0, rsp_last=0, count--.
    - If last -> DONE; else cur_addr+1 mod 2**M and -> RD_ADDR.
  - DONE: done=1 for exactly this cycle, req_ready=0; -> IDLE.
- Latency:
  - Write: 1 beat/cycle at full valid.
  - Read: minimum 3 cycles/beat (RD_ADDR, RD_CAP, RD_RSP with rsp_ready=1).
  - done asserts the cycle after the final beat handshake.
- mem_wr_enb is 0 in every state except WR, so a read and a write never coincide.
- req_len > 2**M is legal: the address wraps and locations are revisited in order.
- wdata_valid outside WR is ignored (wdata_ready=0).
- rsp_ready outside RD_RSP is ignored.
- req_valid is ignored while busy (req_ready=0).
- mem_addr equals cur_addr in all states.

Decomposition:
- Package mem_pkg: state enum (IDLE, WR, RD_ADDR, RD_CAP, RD_RSP, DONE) and default M/N constants.
- Single module; no sub-module needed.
- Bench instantiates the team's single-port synchronous memory (M=3, N=4) as the slave.

Test Plan:
- Write addr=2 len=3 data 0xA,0xB,0xC with wdata_valid constant -> mem_wr_enb high 3 consecutive cycles at mem_addr 2,3,4; done pulse 1 cycle later; busy low after.
- Read addr=2 len=3, rsp_ready=1 -> rsp_data 0xA,0xB,0xC on beats 3 cycles apart; rsp_last only with 0xC; done follows.
- Wrap: write addr=6 len=4 data 1,2,3,4 -> writes at 6,7,0,1. Read addr=6 len=4 -> 1,2,3,4.
- Backpressure: read len=2 with rsp_ready low 5 cycles on beat 1 -> rsp_valid, rsp_data and mem_addr stable for 5 cycles; no beat lost or duplicated.
- wdata_valid pattern 1,0,0,1,1 on write addr=0 len=3 -> writes only in valid cycles at addresses 0,1,2; done after the fifth cycle's beat.
- len=0 -> req handshake, done next cycle, no mem_wr_enb.
- rst_n low after first write beat of len=4 -> all outputs at reset values immediately; only address 0 modified; req_ready=1 after release.
